// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded-style instruction control sequencer FSM
module control_sequencer #(
    parameter int OPW      = 4,
    parameter int MEM_WAIT = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic           zero_flag,
    input  logic           neg_flag,
    output logic [13:0]    ctrl,
    output logic           instr_done,
    output logic           halted,
    output logic [3:0]     state_dbg
);

    localparam int CW = $clog2(MEM_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT - 1);

    localparam logic [OPW-1:0] OP_LDA = OPW'(0);
    localparam logic [OPW-1:0] OP_STA = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_INC = OPW'(5);
    localparam logic [OPW-1:0] OP_CLR = OPW'(6);
    localparam logic [OPW-1:0] OP_JMP = OPW'(7);
    localparam logic [OPW-1:0] OP_JPZ = OPW'(8);
    localparam logic [OPW-1:0] OP_JPN = OPW'(9);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        F_ADDR   = 4'd1,
        F_WAIT   = 4'd2,
        DECODE   = 4'd3,
        DISPATCH = 4'd4,
        O_ADDR   = 4'd5,
        O_WAIT   = 4'd6,
        S_WAIT   = 4'd7,
        EX_LOAD  = 4'd8,
        EX_ALU   = 4'd9,
        EX_INC   = 4'd10,
        EX_CLR   = 4'd11,
        EX_JMP   = 4'd12,
        HALT     = 4'd15
    } state_t;

    state_t         state;
    state_t         state_n;
    state_t         boundary_n;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_n;
    logic [OPW-1:0] op_q;
    logic           wait_last;
    logic           dispatch_done;

    assign wait_last  = (cnt == CNT_LAST);
    assign boundary_n = run ? F_ADDR : IDLE;

    // State, wait counter and latched opcode registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == DISPATCH) begin
                op_q <= opcode;
            end
        end
    end

    // Next-state logic; the counter is zero outside wait states so every wait starts from 0
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        case (state)
            IDLE:     if (run) state_n = F_ADDR;
            F_ADDR:   state_n = F_WAIT;
            F_WAIT: begin
                if (wait_last) state_n = DECODE;
                else           cnt_n   = cnt + CW'(1);
            end
            DECODE:   state_n = DISPATCH;
            DISPATCH: begin
                case (opcode)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_XOR: state_n = O_ADDR;
                    OP_INC: state_n = EX_INC;
                    OP_CLR: state_n = EX_CLR;
                    OP_JMP: state_n = EX_JMP;
                    OP_JPZ: state_n = zero_flag ? EX_JMP : boundary_n;
                    OP_JPN: state_n = neg_flag ? EX_JMP : boundary_n;
                    OP_HLT: state_n = HALT;
                    default: state_n = boundary_n;
                endcase
            end
            O_ADDR:   state_n = (op_q == OP_STA) ? S_WAIT : O_WAIT;
            O_WAIT: begin
                if (wait_last) state_n = (op_q == OP_LDA) ? EX_LOAD : EX_ALU;
                else           cnt_n   = cnt + CW'(1);
            end
            S_WAIT: begin
                if (wait_last) state_n = boundary_n;
                else           cnt_n   = cnt + CW'(1);
            end
            EX_LOAD, EX_ALU, EX_INC, EX_CLR, EX_JMP: state_n = boundary_n;
            HALT:     state_n = HALT;
            default:  state_n = IDLE;
        endcase
    end

    // DISPATCH ends the instruction itself for NOPs and untaken branches, which only the opcode fields can tell
    always_comb begin
        dispatch_done = 1'b0;
        if (state == DISPATCH) begin
            case (opcode)
                OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_XOR,
                OP_INC, OP_CLR, OP_JMP, OP_HLT: dispatch_done = 1'b0;
                OP_JPZ:  dispatch_done = ~zero_flag;
                OP_JPN:  dispatch_done = ~neg_flag;
                default: dispatch_done = 1'b1;
            endcase
        end
    end

    // Control word and status decode from the state register, wait counter and latched opcode
    always_comb begin
        ctrl       = '0;
        instr_done = dispatch_done;
        halted     = (state == HALT);
        state_dbg  = state;
        case (state)
            F_ADDR: begin
                ctrl[0] = 1'b1;
                ctrl[2] = 1'b1;
            end
            F_WAIT, O_WAIT: ctrl[3] = 1'b1;
            DECODE: begin
                ctrl[5] = 1'b1;
                ctrl[6] = 1'b1;
            end
            O_ADDR: begin
                ctrl[1] = 1'b1;
                ctrl[2] = 1'b1;
            end
            S_WAIT: begin
                ctrl[4]    = 1'b1;
                instr_done = wait_last;
            end
            EX_LOAD: begin
                ctrl[10]   = 1'b1;
                instr_done = 1'b1;
            end
            EX_ALU: begin
                ctrl[11] = 1'b1;
                if (op_q == OP_SUB)      ctrl[13:12] = 2'b01;
                else if (op_q == OP_XOR) ctrl[13:12] = 2'b10;
                else                     ctrl[13:12] = 2'b00;
                instr_done = 1'b1;
            end
            EX_INC: begin
                ctrl[8]    = 1'b1;
                instr_done = 1'b1;
            end
            EX_CLR: begin
                ctrl[9]    = 1'b1;
                instr_done = 1'b1;
            end
            EX_JMP: begin
                ctrl[7]    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;

    typedef struct packed {
        logic [3:0]  st;
        logic [13:0] c;
        logic        d;
        logic        h;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        run_a;
    logic        run_b;
    logic [3:0]  opcode;
    logic        zero_flag;
    logic        neg_flag;
    logic [13:0] ctrl_a, ctrl_b;
    logic        done_a, done_b;
    logic        halt_a, halt_b;
    logic [3:0]  st_a, st_b;

    int checks;
    int failures;
    exp_t q[$];

    control_sequencer #(.OPW(4), .MEM_WAIT(2)) dut_a (
        .clock(clock), .reset(reset), .run(run_a), .opcode(opcode),
        .zero_flag(zero_flag), .neg_flag(neg_flag), .ctrl(ctrl_a),
        .instr_done(done_a), .halted(halt_a), .state_dbg(st_a)
    );

    control_sequencer #(.OPW(4), .MEM_WAIT(3)) dut_b (
        .clock(clock), .reset(reset), .run(run_b), .opcode(opcode),
        .zero_flag(zero_flag), .neg_flag(neg_flag), .ctrl(ctrl_b),
        .instr_done(done_b), .halted(halt_b), .state_dbg(st_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t mk(input logic [3:0] st, input logic [13:0] c, input logic d);
        exp_t r;
        r.st = st;
        r.c  = c;
        r.d  = d;
        r.h  = (st == 4'd15);
        return r;
    endfunction

    function automatic exp_t obs(input int w);
        exp_t r;
        if (w == 2) begin
            r.st = st_a; r.c = ctrl_a; r.d = done_a; r.h = halt_a;
        end else begin
            r.st = st_b; r.c = ctrl_b; r.d = done_b; r.h = halt_b;
        end
        return r;
    endfunction

    task automatic check(input string tag, input int idx, input exp_t o, input exp_t e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, idx, o, e);
        end
    endtask

    task automatic set_run(input int w, input logic v);
        if (w == 2) run_a = v;
        else        run_b = v;
    endtask

    // Expected per-cycle trace of one instruction, starting at F_ADDR
    task automatic push_instr(input int w, input logic [3:0] op, input logic z, input logic n);
        q.push_back(mk(4'd1, 14'h0005, 1'b0));
        for (int i = 0; i < w; i++) q.push_back(mk(4'd2, 14'h0008, 1'b0));
        q.push_back(mk(4'd3, 14'h0060, 1'b0));
        case (op)
            4'd0, 4'd2, 4'd3, 4'd4: begin
                q.push_back(mk(4'd4, 14'h0000, 1'b0));
                q.push_back(mk(4'd5, 14'h0006, 1'b0));
                for (int i = 0; i < w; i++) q.push_back(mk(4'd6, 14'h0008, 1'b0));
                if (op == 4'd0)      q.push_back(mk(4'd8, 14'h0400, 1'b1));
                else if (op == 4'd3) q.push_back(mk(4'd9, 14'h1800, 1'b1));
                else if (op == 4'd4) q.push_back(mk(4'd9, 14'h2800, 1'b1));
                else                 q.push_back(mk(4'd9, 14'h0800, 1'b1));
            end
            4'd1: begin
                q.push_back(mk(4'd4, 14'h0000, 1'b0));
                q.push_back(mk(4'd5, 14'h0006, 1'b0));
                for (int i = 0; i < w; i++) q.push_back(mk(4'd7, 14'h0010, i == w - 1));
            end
            4'd5: begin
                q.push_back(mk(4'd4, 14'h0000, 1'b0));
                q.push_back(mk(4'd10, 14'h0100, 1'b1));
            end
            4'd6: begin
                q.push_back(mk(4'd4, 14'h0000, 1'b0));
                q.push_back(mk(4'd11, 14'h0200, 1'b1));
            end
            4'd7: begin
                q.push_back(mk(4'd4, 14'h0000, 1'b0));
                q.push_back(mk(4'd12, 14'h0080, 1'b1));
            end
            4'd8, 4'd9: begin
                if ((op == 4'd8 && z) || (op == 4'd9 && n)) begin
                    q.push_back(mk(4'd4, 14'h0000, 1'b0));
                    q.push_back(mk(4'd12, 14'h0080, 1'b1));
                end else begin
                    q.push_back(mk(4'd4, 14'h0000, 1'b1));
                end
            end
            4'd15: begin
                q.push_back(mk(4'd4, 14'h0000, 1'b0));
                q.push_back(mk(4'd15, 14'h0000, 1'b0));
            end
            default: q.push_back(mk(4'd4, 14'h0000, 1'b1));
        endcase
    endtask

    // Drive one instruction from IDLE, dropping run after cycle drop_idx, and drain the scoreboard
    task automatic exec(input string tag, input int w, input logic [3:0] op, input logic z,
                        input logic n, input int drop_idx, input logic keep);
        int idx;
        exp_t e;
        opcode    = op;
        zero_flag = z;
        neg_flag  = n;
        set_run(w, 1'b1);
        push_instr(w, op, z, n);
        if (op != 4'd15) begin
            if (keep) q.push_back(mk(4'd1, 14'h0005, 1'b0));
            else      q.push_back(mk(4'd0, 14'h0000, 1'b0));
        end
        idx = 0;
        while (q.size() > 0) begin
            @(posedge clock);
            @(negedge clock);
            if (idx == drop_idx) set_run(w, 1'b0);
            e = q.pop_front();
            check(tag, idx, obs(w), e);
            idx++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        run_a     = 1'b0;
        run_b     = 1'b0;
        opcode    = 4'd0;
        zero_flag = 1'b0;
        neg_flag  = 1'b0;
        #1;
        check("reset_a", 0, obs(2), mk(4'd0, 14'h0000, 1'b0));
        check("reset_b", 0, obs(3), mk(4'd0, 14'h0000, 1'b0));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        exec("inc_w2", 2, 4'd5, 1'b0, 1'b0, 0, 1'b0);
        exec("sta_w3", 3, 4'd1, 1'b0, 1'b0, 0, 1'b0);
        exec("jpz_nt", 2, 4'd8, 1'b0, 1'b1, 0, 1'b0);
        exec("jpz_t",  2, 4'd8, 1'b1, 1'b0, 0, 1'b0);
        exec("jpn_nt", 2, 4'd9, 1'b1, 1'b0, 0, 1'b0);
        exec("jpn_t",  2, 4'd9, 1'b0, 1'b1, 0, 1'b0);
        exec("sub",    2, 4'd3, 1'b0, 1'b0, 0, 1'b0);
        exec("xor",    2, 4'd4, 1'b0, 1'b0, 0, 1'b0);
        exec("add_w3", 3, 4'd2, 1'b0, 1'b0, 0, 1'b0);
        exec("lda",    2, 4'd0, 1'b0, 1'b0, 0, 1'b0);
        exec("nop12",  2, 4'd12, 1'b1, 1'b1, 0, 1'b0);
        exec("lda_drop", 3, 4'd0, 1'b0, 1'b0, 7, 1'b0);
        exec("jmp_w3", 3, 4'd7, 1'b0, 1'b0, 0, 1'b0);

        exec("clr_keep", 2, 4'd6, 1'b0, 1'b0, -1, 1'b1);
        run_a = 1'b0;
        pulse_reset();
        check("after_keep_rst", 0, obs(2), mk(4'd0, 14'h0000, 1'b0));

        opcode = 4'd5;
        run_b  = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2;
        check("fwait_b", 0, obs(3), mk(4'd2, 14'h0008, 1'b0));
        reset = 1'b1;
        #1;
        check("rst_async", 0, obs(3), mk(4'd0, 14'h0000, 1'b0));
        @(negedge clock);
        check("rst_hold", 1, obs(3), mk(4'd0, 14'h0000, 1'b0));
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rst_first_edge", 0, obs(3), mk(4'd1, 14'h0005, 1'b0));
        run_b = 1'b0;
        pulse_reset();

        exec("hlt", 2, 4'd15, 1'b0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            run_a = i[0];
            @(posedge clock);
            @(negedge clock);
            check("halt_hold", i, obs(2), mk(4'd15, 14'h0000, 1'b0));
        end
        run_a = 1'b0;
        reset = 1'b1;
        #1;
        check("halt_reset", 0, obs(2), mk(4'd0, 14'h0000, 1'b0));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("halt_idle", 0, obs(2), mk(4'd0, 14'h0000, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
